// File: rtl/tile_buf_pkg.sv
// Shared definitions for the tile staging buffer (read-side reader and write-side loader).
// Contents: default buffer geometry, reader FSM state enum, output FIFO depth,
// and a wrapping address-increment helper.
package tile_buf_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 128;
   localparam int unsigned DEF_DEPTH      = 20;
   localparam int unsigned DEF_LEN_WIDTH  = 16;
   localparam int unsigned FIFO_DEPTH     = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } rd_state_e;

   // Next buffer address, wrapping depth-1 back to 0.
   function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned depth);
      return (addr + 1 == depth) ? 0 : addr + 1;
   endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO between the buffer read port and the output stream.
// Ports: clk, rst (sync, active-high); push/push_data write side;
// pop read side (only when valid); head/valid present the oldest entry
// straight from a register; count is the occupancy 0..2.
module stream_skid_fifo #(
   parameter int unsigned WIDTH = 129
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             valid,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] tail;
   logic [1:0]       count_nxt;

   // Occupancy update.
   always_comb begin
      count_nxt = count;
      if (push && !pop)      count_nxt = count + 2'd1;
      else if (pop && !push) count_nxt = count - 2'd1;
   end

   // Head always holds the oldest word so the stream output is registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 2'd0;
         valid <= 1'b0;
         head  <= '0;
         tail  <= '0;
      end else begin
         count <= count_nxt;
         valid <= (count_nxt != 2'd0);
         if (pop) begin
            if (count == 2'd2) head <= tail;
            else if (push)     head <= push_data;
         end else if (push && count == 2'd0) begin
            head <= push_data;
         end
         if (push && ((count == 2'd1 && !pop) || (count == 2'd2 && pop)))
            tail <= push_data;
      end
   end

endmodule

// File: rtl/tile_buffer_reader.sv
// Read-side controller for the tile staging buffer: walks a wrapping address
// range, absorbs the buffer's 1-cycle read latency and streams words out.
// Ports: clk, rst (sync, active-high); start/base_addr/length command;
// busy/done/err status; rd_addr/rd_data buffer read port;
// m_valid/m_ready/m_data/m_last output stream.
module tile_buffer_reader
   import tile_buf_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned DEPTH      = DEF_DEPTH,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
   parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  length,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last
);

   localparam int unsigned FIFO_WIDTH = DATA_WIDTH + 1;

   rd_state_e             state, state_nxt;
   logic [LEN_WIDTH-1:0]  remaining;
   logic                  inflight, inflight_last;
   logic [1:0]            fifo_count, occupancy;
   logic [FIFO_WIDTH-1:0] fifo_head;
   logic                  pop, issue, accept, credit;
   logic                  busy_nxt, done_nxt, err_nxt;

   assign pop    = m_valid & m_ready;
   assign m_data = fifo_head[DATA_WIDTH-1:0];
   assign m_last = fifo_head[DATA_WIDTH];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state, read issue and status pulses. A read may issue when the FIFO
   // plus the in-flight read leave room, counting a slot freed by this cycle's pop.
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      issue     = 1'b0;
      accept    = 1'b0;
      occupancy = fifo_count + 2'(inflight);
      credit    = (occupancy < 2'(FIFO_DEPTH)) || ((occupancy == 2'(FIFO_DEPTH)) && pop);
      unique case (state)
         IDLE: begin
            if (start) begin
               if (length == '0) begin
                  done_nxt = 1'b1;
               end else if (32'(base_addr) >= DEPTH) begin
                  done_nxt = 1'b1;
                  err_nxt  = 1'b1;
               end else begin
                  accept    = 1'b1;
                  state_nxt = STREAM;
               end
            end
         end
         STREAM: begin
            if (credit) begin
               issue = 1'b1;
               if (remaining == LEN_WIDTH'(1)) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && m_last) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   // Registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
         err  <= 1'b0;
      end else begin
         busy <= busy_nxt;
         done <= done_nxt;
         err  <= err_nxt;
      end
   end

   // Address/length counters and the in-flight read tracker; rd_addr holds
   // the next address to issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr       <= '0;
         remaining     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         inflight      <= issue;
         inflight_last <= issue && (remaining == LEN_WIDTH'(1));
         if (accept) begin
            rd_addr   <= base_addr;
            remaining <= length;
         end else if (issue) begin
            rd_addr   <= ADDR_WIDTH'(wrap_inc(32'(rd_addr), DEPTH));
            remaining <= remaining - LEN_WIDTH'(1);
         end
      end
   end

   stream_skid_fifo #(.WIDTH(FIFO_WIDTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data ({inflight_last, rd_data}),
      .pop       (pop),
      .head      (fifo_head),
      .valid     (m_valid),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_tile_buffer_reader.sv
// Directed bench for tile_buffer_reader with a behavioural buffer model.
module tb_tile_buffer_reader;

   localparam int unsigned DW = 128;
   localparam int unsigned DEPTH = 20;
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = 16;

   logic clk = 1'b0;
   logic rst, start, m_ready;
   logic [AW-1:0] base_addr;
   logic [LW-1:0] length;
   logic busy, done, err, m_valid, m_last;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data, m_data;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [DW-1:0] beat_data[$];
   logic          beat_last[$];
   int            beat_cyc[$];
   int done_count, err_count, done_cyc, err_cyc, stall_errs, max_cnt;
   logic valid_seen, busy_seen, hold_pending, held_last;
   logic [DW-1:0] held_data;

   always #5 clk = ~clk;

   tile_buffer_reader dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
      .busy(busy), .done(done), .err(err), .rd_addr(rd_addr), .rd_data(rd_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
   );

   function automatic logic [DW-1:0] word_at(input int unsigned a);
      return {32'hC0DE_0000 + a, ~a, a * 32'h0101_0101, 32'h5A5A_0000 ^ a};
   endfunction

   // Buffer read port: registers the address, data valid the next cycle.
   always @(posedge clk) rd_data <= word_at(32'(rd_addr));

   task automatic clear_stats();
      beat_data.delete(); beat_last.delete(); beat_cyc.delete();
      done_count = 0; err_count = 0; done_cyc = -1; err_cyc = -1;
      stall_errs = 0; max_cnt = 0; valid_seen = 0; busy_seen = 0; hold_pending = 0;
   endtask

   // One cycle: apply inputs at the falling edge, then record what the DUT shows.
   task automatic drive_cycle(input logic st, input logic rdy, input logic rs, input logic st_on_done);
      @(negedge clk);
      cyc++;
      rst = rs;
      start = st | (st_on_done & done);
      m_ready = rdy;
      if (hold_pending && (!m_valid || m_data !== held_data || m_last !== held_last)) stall_errs++;
      hold_pending = m_valid && !m_ready && !rs;
      held_data = m_data;
      held_last = m_last;
      if (32'(dut.fifo_count) > max_cnt) max_cnt = 32'(dut.fifo_count);
      if (done) begin done_count++; done_cyc = cyc; end
      if (err)  begin err_count++;  err_cyc  = cyc; end
      if (busy) busy_seen = 1;
      if (m_valid) valid_seen = 1;
      if (m_valid && m_ready && !rs) begin
         beat_data.push_back(m_data); beat_last.push_back(m_last); beat_cyc.push_back(cyc);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) drive_cycle(0, 0, 1, 0);
      drive_cycle(0, 0, 0, 0);
      vectors++; if (busy !== 1'b0)    begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (done !== 1'b0)    begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
      vectors++; if (err !== 1'b0)     begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
      vectors++; if (rd_addr !== '0)   begin miscompares++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
      vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
      vectors++; if (m_last !== 1'b0)  begin miscompares++; $display("FAIL reset_m_last: got %b want 0", m_last); end
      vectors++; if (m_data !== '0)    begin miscompares++; $display("FAIL reset_m_data: got %h want 0", m_data); end
   endtask

   task automatic test_basic();
      int s;
      logic [DW-1:0] got;
      clear_stats();
      base_addr = 0; length = 4;
      drive_cycle(1, 1, 0, 0); s = cyc;
      drive_cycle(0, 1, 0, 0);
      vectors++; if (busy !== 1'b1)  begin miscompares++; $display("FAIL basic_busy: got %b want 1", busy); end
      vectors++; if (rd_addr !== 0)  begin miscompares++; $display("FAIL basic_first_addr: got %0d want 0", rd_addr); end
      for (int i = 0; i < 40 && done_count == 0; i++) drive_cycle(0, 1, 0, 0);
      vectors++; if (beat_data.size() != 4) begin miscompares++; $display("FAIL basic_beats: got %0d want 4", beat_data.size()); end
      vectors++; if (beat_cyc.size() == 0 || beat_cyc[0] != s + 3) begin miscompares++; $display("FAIL basic_first_valid: got cyc %0d want %0d", beat_cyc.size() ? beat_cyc[0] : -1, s + 3); end
      for (int k = 0; k < 4; k++) begin
         got = (k < beat_data.size()) ? beat_data[k] : 'x;
         vectors++; if (got !== word_at(k)) begin miscompares++; $display("FAIL basic_data%0d: got %h want %h", k, got, word_at(k)); end
         vectors++; if (k < beat_last.size() && beat_last[k] !== (k == 3)) begin miscompares++; $display("FAIL basic_last%0d: got %b want %b", k, beat_last[k], k == 3); end
      end
      vectors++; if (done_cyc != s + 7) begin miscompares++; $display("FAIL basic_done_cyc: got %0d want %0d", done_cyc, s + 7); end
      vectors++; if (err_count != 0) begin miscompares++; $display("FAIL basic_err: got %0d want 0", err_count); end
   endtask

   task automatic test_wrap();
      int s;
      logic [DW-1:0] got, exp;
      clear_stats();
      base_addr = 18; length = 5;
      drive_cycle(1, 1, 0, 0); s = cyc;
      for (int i = 0; i < 40 && done_count == 0; i++) drive_cycle(0, 1, 0, 0);
      vectors++; if (beat_data.size() != 5) begin miscompares++; $display("FAIL wrap_beats: got %0d want 5", beat_data.size()); end
      for (int k = 0; k < 5; k++) begin
         got = (k < beat_data.size()) ? beat_data[k] : 'x;
         exp = word_at((18 + k) % DEPTH);
         vectors++; if (got !== exp) begin miscompares++; $display("FAIL wrap_data%0d: got %h want %h", k, got, exp); end
      end
      vectors++; if (done_cyc != s + 8) begin miscompares++; $display("FAIL wrap_done_cyc: got %0d want %0d", done_cyc, s + 8); end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] got;
      int nlast;
      clear_stats();
      base_addr = 3; length = 8;
      drive_cycle(1, 1'($urandom_range(0, 1)), 0, 0);
      for (int i = 0; i < 300 && done_count == 0; i++) drive_cycle(0, 1'($urandom_range(0, 1)), 0, 0);
      vectors++; if (beat_data.size() != 8) begin miscompares++; $display("FAIL bp_beats: got %0d want 8", beat_data.size()); end
      for (int k = 0; k < 8; k++) begin
         got = (k < beat_data.size()) ? beat_data[k] : 'x;
         vectors++; if (got !== word_at(3 + k)) begin miscompares++; $display("FAIL bp_data%0d: got %h want %h", k, got, word_at(3 + k)); end
      end
      nlast = 0;
      foreach (beat_last[k]) if (beat_last[k]) nlast++;
      vectors++; if (nlast != 1 || beat_last.size() != 8 || beat_last[7] !== 1'b1) begin miscompares++; $display("FAIL bp_last: got %0d last flags want 1 on beat 7", nlast); end
      vectors++; if (stall_errs != 0) begin miscompares++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_errs); end
      vectors++; if (max_cnt > 2)     begin miscompares++; $display("FAIL bp_occupancy: got %0d want <=2", max_cnt); end
      vectors++; if (done_count != 1) begin miscompares++; $display("FAIL bp_done: got %0d want 1", done_count); end
   endtask

   task automatic test_zero_and_err();
      int s;
      clear_stats();
      base_addr = 2; length = 0;
      drive_cycle(1, 1, 0, 0); s = cyc;
      for (int i = 0; i < 4; i++) drive_cycle(0, 1, 0, 0);
      vectors++; if (done_cyc != s + 1 || done_count != 1) begin miscompares++; $display("FAIL zero_done: got cyc %0d count %0d want cyc %0d count 1", done_cyc, done_count, s + 1); end
      vectors++; if (err_count != 0) begin miscompares++; $display("FAIL zero_err: got %0d want 0", err_count); end
      vectors++; if (valid_seen || busy_seen) begin miscompares++; $display("FAIL zero_quiet: got valid %b busy %b want 0 0", valid_seen, busy_seen); end
      clear_stats();
      base_addr = 25; length = 3;
      drive_cycle(1, 1, 0, 0); s = cyc;
      for (int i = 0; i < 6; i++) drive_cycle(0, 1, 0, 0);
      vectors++; if (done_cyc != s + 1 || done_count != 1) begin miscompares++; $display("FAIL badbase_done: got cyc %0d count %0d want cyc %0d count 1", done_cyc, done_count, s + 1); end
      vectors++; if (err_cyc != s + 1 || err_count != 1) begin miscompares++; $display("FAIL badbase_err: got cyc %0d count %0d want cyc %0d count 1", err_cyc, err_count, s + 1); end
      vectors++; if (valid_seen) begin miscompares++; $display("FAIL badbase_beats: got valid %b want 0", valid_seen); end
   endtask

   task automatic test_back_to_back();
      int s, d1;
      logic [DW-1:0] got, exp;
      clear_stats();
      base_addr = 0; length = 6;
      drive_cycle(1, 1, 0, 0); s = cyc;
      drive_cycle(0, 1, 0, 0);
      base_addr = 10; length = 2;
      drive_cycle(1, 1, 0, 0);
      base_addr = 7; length = 2;
      for (int i = 0; i < 40 && done_count == 0; i++) drive_cycle(0, 1, 0, 1);
      d1 = done_cyc;
      for (int i = 0; i < 40 && done_count < 2; i++) drive_cycle(0, 1, 0, 0);
      vectors++; if (d1 != s + 9) begin miscompares++; $display("FAIL b2b_first_done: got %0d want %0d", d1, s + 9); end
      vectors++; if (beat_data.size() != 8) begin miscompares++; $display("FAIL b2b_beats: got %0d want 8", beat_data.size()); end
      for (int k = 0; k < 8; k++) begin
         got = (k < beat_data.size()) ? beat_data[k] : 'x;
         exp = (k < 6) ? word_at(k) : word_at(k + 1);
         vectors++; if (got !== exp) begin miscompares++; $display("FAIL b2b_data%0d: got %h want %h", k, got, exp); end
      end
      vectors++; if (beat_cyc.size() < 7 || beat_cyc[6] != d1 + 3) begin miscompares++; $display("FAIL b2b_second_start: got cyc %0d want %0d", beat_cyc.size() > 6 ? beat_cyc[6] : -1, d1 + 3); end
      vectors++; if (done_count != 2) begin miscompares++; $display("FAIL b2b_done_count: got %0d want 2", done_count); end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] got;
      clear_stats();
      base_addr = 0; length = 10;
      drive_cycle(1, 1, 0, 0);
      for (int i = 0; i < 20 && beat_data.size() < 3; i++) drive_cycle(0, 1, 0, 0);
      drive_cycle(0, 1, 1, 0);
      drive_cycle(0, 1, 0, 0);
      vectors++; if ({busy, done, err, m_valid, m_last} !== 5'b0) begin miscompares++; $display("FAIL midrst_flags: got %b want 00000", {busy, done, err, m_valid, m_last}); end
      vectors++; if (rd_addr !== '0 || m_data !== '0) begin miscompares++; $display("FAIL midrst_regs: got addr %0d data %h want 0 0", rd_addr, m_data); end
      clear_stats();
      for (int i = 0; i < 6; i++) drive_cycle(0, 1, 0, 0);
      vectors++; if (done_count != 0 || valid_seen) begin miscompares++; $display("FAIL midrst_quiet: got done %0d valid %b want 0 0", done_count, valid_seen); end
      clear_stats();
      base_addr = 5; length = 3;
      drive_cycle(1, 1, 0, 0);
      for (int i = 0; i < 40 && done_count == 0; i++) drive_cycle(0, 1, 0, 0);
      vectors++; if (beat_data.size() != 3 || done_count != 1) begin miscompares++; $display("FAIL midrst_rerun: got beats %0d done %0d want 3 1", beat_data.size(), done_count); end
      for (int k = 0; k < 3; k++) begin
         got = (k < beat_data.size()) ? beat_data[k] : 'x;
         vectors++; if (got !== word_at(5 + k)) begin miscompares++; $display("FAIL midrst_data%0d: got %h want %h", k, got, word_at(5 + k)); end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; m_ready = 1'b0; base_addr = '0; length = '0;
      clear_stats();
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero_and_err();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
